// File: rtl/imc_seq_ctrl.sv
// rtl/imc_seq_ctrl.sv - sequencing FSM for the 2x2 matrix-inverse datapath
//
// Runs one inversion per accepted start:
//   INIT -> DET -> RECIP -> OUT_AD -> OUT_BC -> DONE -> IDLE
// Each multiply phase (DET, OUT_AD, OUT_BC) lasts 1+MUL_WAIT cycles.
// Its selects stay constant for the whole phase. Its load strobes fire only
// in the last cycle, which gives a slow multiplier time to settle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 inversion request, sampled only in IDLE
//   busy, done            busy from INIT to DONE, done is a one-cycle pulse
//   mul{1,2}_{a,b}_sel    datapath multiplier operand selects
//   mul{1,2}_sel_out      product slice select (1=[31:16], 0=[23:8])
//   init_*, load_*        datapath register clears and loads
module imc_seq_ctrl #(
    parameter int MUL_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] mul1_a_sel,
    output logic [1:0] mul1_b_sel,
    output logic [1:0] mul2_a_sel,
    output logic [1:0] mul2_b_sel,
    output logic       mul1_sel_out,
    output logic       mul2_sel_out,
    output logic       init_multi1,
    output logic       init_multi2,
    output logic       init_det,
    output logic       init_sign,
    output logic       init_aout,
    output logic       init_aOut_sign,
    output logic       init_bout,
    output logic       init_bOut_sign,
    output logic       init_cout,
    output logic       init_cOut_sign,
    output logic       init_dout,
    output logic       init_dOut_sign,
    output logic       load_multi1,
    output logic       load_multi2,
    output logic       load_det,
    output logic       load_sign,
    output logic       load_aout,
    output logic       load_aOut_sign,
    output logic       load_bout,
    output logic       load_bOut_sign,
    output logic       load_cout,
    output logic       load_cOut_sign,
    output logic       load_dout,
    output logic       load_dOut_sign
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DET,
        RECIP,
        OUT_AD,
        OUT_BC,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MUL_WAIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       in_mul;
    logic       last;

    assign in_mul = (state == DET) || (state == OUT_AD) || (state == OUT_BC);
    assign last   = (wait_cnt == WAIT_LAST);

    // The counter returns to zero at the end of every multiply phase.
    // The next phase therefore always starts from a cleared count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (in_mul && !last)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b1;
        done           = 1'b0;
        mul1_a_sel     = 2'b00;
        mul1_b_sel     = 2'b00;
        mul2_a_sel     = 2'b00;
        mul2_b_sel     = 2'b00;
        mul1_sel_out   = 1'b0;
        mul2_sel_out   = 1'b0;
        init_multi1    = 1'b0;
        init_multi2    = 1'b0;
        init_det       = 1'b0;
        init_sign      = 1'b0;
        init_aout      = 1'b0;
        init_aOut_sign = 1'b0;
        init_bout      = 1'b0;
        init_bOut_sign = 1'b0;
        init_cout      = 1'b0;
        init_cOut_sign = 1'b0;
        init_dout      = 1'b0;
        init_dOut_sign = 1'b0;
        load_multi1    = 1'b0;
        load_multi2    = 1'b0;
        load_det       = 1'b0;
        load_sign      = 1'b0;
        load_aout      = 1'b0;
        load_aOut_sign = 1'b0;
        load_bout      = 1'b0;
        load_bOut_sign = 1'b0;
        load_cout      = 1'b0;
        load_cOut_sign = 1'b0;
        load_dout      = 1'b0;
        load_dOut_sign = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = INIT;
            end
            INIT: begin
                init_multi1    = 1'b1;
                init_multi2    = 1'b1;
                init_det       = 1'b1;
                init_sign      = 1'b1;
                init_aout      = 1'b1;
                init_aOut_sign = 1'b1;
                init_bout      = 1'b1;
                init_bOut_sign = 1'b1;
                init_cout      = 1'b1;
                init_cOut_sign = 1'b1;
                init_dout      = 1'b1;
                init_dOut_sign = 1'b1;
                state_nxt      = DET;
            end
            DET: begin
                // mul1 = a*d, mul2 = b*c
                if (last) begin
                    load_multi1 = 1'b1;
                    load_multi2 = 1'b1;
                    state_nxt   = RECIP;
                end
            end
            RECIP: begin
                load_det  = 1'b1;
                load_sign = 1'b1;
                state_nxt = OUT_AD;
            end
            OUT_AD: begin
                // mul1 = recip*d, mul2 = recip*a
                mul1_a_sel = 2'b01;
                mul1_b_sel = 2'b01;
                mul2_a_sel = 2'b01;
                mul2_b_sel = 2'b10;
                if (last) begin
                    load_aout      = 1'b1;
                    load_aOut_sign = 1'b1;
                    load_dout      = 1'b1;
                    load_dOut_sign = 1'b1;
                    state_nxt      = OUT_BC;
                end
            end
            OUT_BC: begin
                // mul1 = recip*c, mul2 = recip*b
                mul1_a_sel = 2'b10;
                mul1_b_sel = 2'b10;
                mul2_a_sel = 2'b01;
                mul2_b_sel = 2'b01;
                if (last) begin
                    load_cout      = 1'b1;
                    load_cOut_sign = 1'b1;
                    load_bout      = 1'b1;
                    load_bOut_sign = 1'b1;
                    state_nxt      = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imc_seq_ctrl.sv
// tb/tb_imc_seq_ctrl.sv - randomized check of imc_seq_ctrl against a schedule model
module tb_imc_seq_ctrl;

    logic clk;
    logic rst;
    logic start;

    int n_checks;
    int n_fails;

    // Packed output vector layout (MSB first):
    // busy, done, mul1_a_sel, mul1_b_sel, mul2_a_sel, mul2_b_sel,
    // mul1_sel_out, mul2_sel_out, init[11:0], load[11:0].
    // Register order in init/load, from bit 11 down to bit 0:
    // multi1, multi2, det, sign, aout, aOut_sign, bout, bOut_sign,
    // cout, cOut_sign, dout, dOut_sign.
    logic [35:0] vec [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic        busy;
        logic        done;
        logic [1:0]  m1a;
        logic [1:0]  m1b;
        logic [1:0]  m2a;
        logic [1:0]  m2b;
        logic        so1;
        logic        so2;
        logic [11:0] ini;
        logic [11:0] ld;

        imc_seq_ctrl #(.MUL_WAIT(gi * 2)) dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start),
            .busy           (busy),
            .done           (done),
            .mul1_a_sel     (m1a),
            .mul1_b_sel     (m1b),
            .mul2_a_sel     (m2a),
            .mul2_b_sel     (m2b),
            .mul1_sel_out   (so1),
            .mul2_sel_out   (so2),
            .init_multi1    (ini[11]),
            .init_multi2    (ini[10]),
            .init_det       (ini[9]),
            .init_sign      (ini[8]),
            .init_aout      (ini[7]),
            .init_aOut_sign (ini[6]),
            .init_bout      (ini[5]),
            .init_bOut_sign (ini[4]),
            .init_cout      (ini[3]),
            .init_cOut_sign (ini[2]),
            .init_dout      (ini[1]),
            .init_dOut_sign (ini[0]),
            .load_multi1    (ld[11]),
            .load_multi2    (ld[10]),
            .load_det       (ld[9]),
            .load_sign      (ld[8]),
            .load_aout      (ld[7]),
            .load_aOut_sign (ld[6]),
            .load_bout      (ld[5]),
            .load_bOut_sign (ld[4]),
            .load_cout      (ld[3]),
            .load_cOut_sign (ld[2]),
            .load_dout      (ld[1]),
            .load_dOut_sign (ld[0])
        );

        assign vec[gi] = {busy, done, m1a, m1b, m2a, m2b, so1, so2, ini, ld};
    end

    // Reference model: an operation is fully described by whether one is
    // running and how many cycles ago start was accepted (offset 1 = INIT).
    int  mw       [2] = '{0, 2};
    bit  act      [2];
    int  ofs      [2];
    int  done_exp [2];
    int  done_got [2];

    function automatic logic [35:0] expected(bit a, int t, int w);
        logic       busy_e;
        logic       done_e;
        logic [7:0] sel_e;
        logic [11:0] ini_e;
        logic [11:0] ld_e;
        busy_e = 1'b0;
        done_e = 1'b0;
        sel_e  = 8'h00;
        ini_e  = 12'h000;
        ld_e   = 12'h000;
        if (a) begin
            busy_e = 1'b1;
            if (t == 1) begin
                ini_e = 12'hFFF;
            end else if (t <= 2 + w) begin
                if (t == 2 + w) ld_e = 12'hC00;
            end else if (t == 3 + w) begin
                ld_e = 12'h300;
            end else if (t <= 4 + 2 * w) begin
                sel_e = 8'b01_01_01_10;
                if (t == 4 + 2 * w) ld_e = 12'h0C3;
            end else if (t <= 5 + 3 * w) begin
                sel_e = 8'b10_10_01_01;
                if (t == 5 + 3 * w) ld_e = 12'h03C;
            end else begin
                done_e = 1'b1;
            end
        end
        return {busy_e, done_e, sel_e, 2'b00, ini_e, ld_e};
    endfunction

    task automatic check_eq(string tag, logic [35:0] got, logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(logic r, logic s);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                act[i] = 1'b0;
            end else if (act[i]) begin
                ofs[i]++;
                if (ofs[i] == 7 + 3 * mw[i]) act[i] = 1'b0;
            end else if (s) begin
                act[i] = 1'b1;
                ofs[i] = 1;
            end
            if (act[i] && ofs[i] == 6 + 3 * mw[i]) done_exp[i]++;
        end
    endtask

    // Compare the current cycle, then drive inputs for the next edge.
    task automatic step(logic r, logic s);
        @(negedge clk);
        check_eq("outputs_mw0", vec[0], expected(act[0], ofs[0], mw[0]));
        check_eq("outputs_mw2", vec[1], expected(act[1], ofs[1], mw[1]));
        if (vec[0][34] === 1'b1) done_got[0]++;
        if (vec[1][34] === 1'b1) done_got[1]++;
        rst   = r;
        start = s;
        @(posedge clk);
        model_edge(r, s);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 2; i++) begin
            act[i]      = 1'b0;
            ofs[i]      = 0;
            done_exp[i] = 0;
            done_got[i] = 0;
        end
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);

        // Reset held with start high, then a single start pulse
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0);

        // Reset during OUT_AD, followed by an immediate new start
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (14) step(1'b0, 1'b0);

        // Start held high for back-to-back operations
        repeat (40) step(1'b0, 1'b1);
        repeat (14) step(1'b0, 1'b0);

        // Random start and reset traffic
        repeat (800) step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0));
        step(1'b0, 1'b0);

        check_eq("done_count_mw0", 36'(done_got[0]), 36'(done_exp[0]));
        check_eq("done_count_mw2", 36'(done_got[1]), 36'(done_exp[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/imc_seq_ctrl.md
Name: imc_seq_ctrl

Overview:
- Control FSM for the 2x2 matrix-inverse datapath `imc_dp`. It drives every mux select, output-slice select, init and load strobe on that datapath.
- Each operation runs a fixed sequence: clear, determinant products, reciprocal and sign capture, then two phases of output products.
- It has a start/busy/done handshake toward the host.
- MUL_WAIT stretches each multiply phase to cover a multiplier with extra settling or pipeline cycles.

Parameters:
- MUL_WAIT, 0, extra cycles held in each multiply phase (DET, OUT_AD, OUT_BC) before the load strobe fires; range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  request an inversion; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse; datapath outputs valid
- mul1_a_sel, mul1_b_sel, mul2_a_sel, mul2_b_sel  out  2 each  datapath mux selects
- mul1_sel_out, mul2_sel_out  out  1 each  product slice: 1=[31:16], 0=[23:8]
- init_multi1, init_multi2, init_det, init_sign, init_aout, init_aOut_sign, init_bout, init_bOut_sign, init_cout, init_cOut_sign, init_dout, init_dOut_sign  out  1 each  synchronous clears
- load_* (the same 12 names with load_ prefix)  out  1 each  register loads

Interface (already decided):
- One clock; reset is synchronous and active-high.

Behaviour:
- Moore outputs decoded from the registered state; no output depends combinationally on start.
- Reset / IDLE values:
  - rst high at a clk edge puts the FSM in IDLE and clears the wait counter.
  - All outputs are 0 in IDLE and in reset: busy=0, done=0, all selects 00, all sel_out 0, all init/load 0.
- States and outputs (unlisted outputs are 0):
  - IDLE: start=1 -> INIT; else stay.
  - INIT (1 cycle): all 12 init_* =1. -> DET.
  - DET (1+MUL_WAIT cycles):
    - all four mul selects 00 (mul1=a*d, mul2=b*c), sel_out both 0.
    - load_multi1 and load_multi2 =1 only in the last cycle. -> RECIP.
  - RECIP (1 cycle): load_det=1, load_sign=1. -> OUT_AD.
  - OUT_AD (1+MUL_WAIT cycles):
    - mul1_a_sel=01, mul1_b_sel=01 (recip*d).
    - mul2_a_sel=01, mul2_b_sel=10 (recip*a).
    - sel_out both 0.
    - Last cycle only: load_aout, load_aOut_sign, load_dout, load_dOut_sign =1. -> OUT_BC.
  - OUT_BC (1+MUL_WAIT cycles):
    - mul1_a_sel=10, mul1_b_sel=10 (recip*c).
    - mul2_a_sel=01, mul2_b_sel=01 (recip*b).
    - sel_out both 0.
    - Last cycle only: load_cout, load_cOut_sign, load_bout, load_bOut_sign =1. -> DONE.
  - DONE (1 cycle): done=1. -> IDLE.
- busy=1 in INIT through DONE inclusive.
- Wait counter:
  - 4-bit; cleared on entry to each multiply phase; increments each cycle in the phase.
  - Phase ends when counter == MUL_WAIT.
  - Mux selects are held constant for the whole phase.
- Latency:
  - start sampled at edge k -> done high during cycle k+6+3*MUL_WAIT.
  - Total busy cycles = 6+3*MUL_WAIT.
- Boundary conditions:
  - start while busy (any non-IDLE state, including DONE): ignored; no queueing.
  - start held high continuously: a new operation is accepted in the IDLE cycle that follows DONE (back-to-back spacing 7+3*MUL_WAIT cycles).
  - rst and start high on the same edge: rst wins; IDLE next cycle.
  - rst mid-operation: IDLE next cycle; all strobes drop immediately. Partially loaded datapath registers are not cleaned up; the next operation's INIT clears them.
  - Each load_* is asserted exactly once per operation and never in the same cycle as its own init_*.
  - Datapath outputs stay stable after done until the next INIT.

Test Plan:
- Reset sequence: assert rst for 2 cycles with start=1 -> busy=0, done=0, every control output 0; after rst release, start is accepted only once rst is low.
- MUL_WAIT=0, single start pulse at cycle 0 -> INIT@1, DET@2 (load_multi1/2), RECIP@3, OUT_AD@4, OUT_BC@5, done@6. Check that exact select/load vector in each cycle.
- MUL_WAIT=2 -> each multiply phase lasts 3 cycles; loads fire only in the third; selects constant across the phase; done at cycle 12.
- Start pulses at cycles 3 and 6 during an operation (MUL_WAIT=0) -> ignored: exactly one done, one load per register.
- rst asserted during OUT_AD, then a new start -> IDLE the cycle after rst. The new run shows a full INIT pulse, and done arrives 6 cycles after the new start.
- Integrated with `imc_dp`:
  - a=d=0x0100, b=c=0x0000 -> aOut==dOut nonzero, bOut=cOut=0x0000, aOut_sign=dOut_sign=0, bOut_sign=cOut_sign=1.
  - a=0x0100, b=0x0200, c=0x0300, d=0x0100 (ad<bc) -> aOut_sign=1.
